ultrasonic_scheduler: RTL and testbench

Round-robin controller for NUM_SENSORS ultrasonic rangefinders on the robot. The sensors share one time slot, so only one of them fires at a time to avoid acoustic crosstalk. For each sensor the block issues the trigger pulse, times the echo pulse width in clk cycles, stores a per-sensor distance, and raises a registered stop flag when any valid distance is under threshold. It sits between the PMOD sensor pins and the motor/stop logic, and replaces free-running per-sensor PWM timing.

---
 rtl/ultrasonic_scheduler_if.sv | 45 ++++
 rtl/ultrasonic_scheduler.sv | 250 +++++++++++++++++++++++++
 tb/tb_ultrasonic_scheduler.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ultrasonic_scheduler_if.sv
// ultrasonic_scheduler_if
//   Sensor-side and readback signal bundle for ultrasonic_scheduler.
//   master modport: system side. It drives enable, echo, threshold and dist_sel,
//                   and it observes the results.
//   slave  modport: the scheduler itself.
//   Signals:
//     enable      run sequencing
//     echo        raw echo pins (asynchronous)
//     threshold   stop threshold in clk cycles
//     dist_sel    readback sensor index
//     trigger     trigger pins, one-hot or zero
//     dist_out    stored distance of sensor dist_sel
//     dist_valid  per-sensor "has a completed sample"
//     timeout     per-sensor "last sample timed out"
//     active_idx  sensor currently sequenced
//     sample_done one-cycle pulse per distance write
//     stop        registered near-obstacle flag
interface ultrasonic_scheduler_if #(
  parameter int NUM_SENSORS = 3,
  parameter int CNT_W       = 25
);
  localparam int IDX_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

  logic                   enable;
  logic [NUM_SENSORS-1:0] echo;
  logic [CNT_W-1:0]       threshold;
  logic [IDX_W-1:0]       dist_sel;
  logic [NUM_SENSORS-1:0] trigger;
  logic [CNT_W-1:0]       dist_out;
  logic [NUM_SENSORS-1:0] dist_valid;
  logic [NUM_SENSORS-1:0] timeout;
  logic [IDX_W-1:0]       active_idx;
  logic                   sample_done;
  logic                   stop;

  modport master (
    output enable, echo, threshold, dist_sel,
    input  trigger, dist_out, dist_valid, timeout, active_idx, sample_done, stop
  );

  modport slave (
    input  enable, echo, threshold, dist_sel,
    output trigger, dist_out, dist_valid, timeout, active_idx, sample_done, stop
  );
endinterface

// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler
//   Round-robin sequencer for NUM_SENSORS ultrasonic rangefinders sharing one
//   acoustic slot. For each sensor in turn, the block performs these steps:
//     1. pulse its trigger pin;
//     2. time the synchronised echo width in clk cycles;
//     3. store the per-sensor distance;
//     4. wait a guard time before moving to the next sensor.
//   stop is raised, one cycle after the write, whenever any valid,
//   non-timed-out distance is below threshold.
//   Ports:
//     clk  system clock
//     rst  synchronous reset, active-high
//     bus  ultrasonic_scheduler_if.slave (enable, echo, threshold, dist_sel in;
//          trigger, dist_out, dist_valid, timeout, active_idx, sample_done,
//          stop out)
//   Build option:
//     ULTRASONIC_AVG_EN  when defined, a successful sample following a valid,
//                        non-timed-out one stores (old+new)>>1 instead of the
//                        raw width.
module ultrasonic_scheduler #(
  parameter int NUM_SENSORS  = 3,
  parameter int CNT_W        = 25,
  parameter int TRIG_CYCLES  = 1000,
  parameter int ECHO_TIMEOUT = 3750000,
  parameter int GUARD_CYCLES = 1000000
) (
  input logic                   clk,
  input logic                   rst,
  ultrasonic_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

  localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WIDTH_MAX  = CNT_W'(ECHO_TIMEOUT);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_SENSORS - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GUARD
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic [NUM_SENSORS-1:0] echo_meta, echo_sync, echo_prev;
  logic                   echo_cur, echo_last;

  logic [CNT_W-1:0]       dist_q [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] valid_q, timeout_q;
  logic                   sample_done_q, stop_q, stop_d;

  logic                   wr_en, wr_to;
  logic [CNT_W-1:0]       wr_val;

  logic [NUM_SENSORS-1:0] trig;
  logic [CNT_W-1:0]       dist_mux;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_meta <= '0;
      echo_sync <= '0;
      echo_prev <= '0;
    end else begin
      echo_meta <= bus.echo;
      echo_sync <= echo_meta;
      echo_prev <= echo_sync;
    end
  end

  always_comb begin
    echo_cur  = 1'b0;
    echo_last = 1'b0;
    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        echo_cur  = echo_sync[i];
        echo_last = echo_prev[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    wr_to   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_RISE: begin
        // The rising-edge cycle is already one high cycle, so MEASURE starts at 1.
        if (echo_cur && !echo_last) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == WAIT_LAST) begin
          wr_en   = 1'b1;
          wr_to   = 1'b1;
          state_d = GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEASURE: begin
        // The echo is still high with the counter already at the maximum
        // width. The pulse is longer than the maximum, so it is a timeout.
        if (!echo_cur && echo_last) begin
          wr_en   = 1'b1;
          state_d = GUARD;
          cnt_d   = '0;
        end else if (cnt_q == WIDTH_MAX) begin
          wr_en   = 1'b1;
          wr_to   = 1'b1;
          state_d = GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          state_d = bus.enable ? TRIG : IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef ULTRASONIC_AVG_EN
  logic [CNT_W-1:0] cur_dist;
  logic             cur_keep;
  logic [CNT_W:0]   avg_sum;

  always_comb begin
    cur_dist = '0;
    cur_keep = 1'b0;
    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_dist = dist_q[i];
        cur_keep = valid_q[i] & ~timeout_q[i];
      end
    end
  end

  assign avg_sum = {1'b0, cur_dist} + {1'b0, cnt_q};
  assign wr_val  = cur_keep ? avg_sum[CNT_W:1] : cnt_q;
`else
  assign wr_val = cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
        dist_q[i] <= '1;
      end
      valid_q       <= '0;
      timeout_q     <= '0;
      sample_done_q <= 1'b0;
      stop_q        <= 1'b0;
    end else begin
      sample_done_q <= wr_en;
      stop_q        <= stop_d;
      for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
        if (wr_en && idx_q == IDX_W'(i)) begin
          dist_q[i]    <= wr_to ? '1 : wr_val;
          timeout_q[i] <= wr_to;
          valid_q[i]   <= 1'b1;
        end
      end
    end
  end

  // Evaluated from stored values, so stop lags each write by one cycle.
  always_comb begin
    stop_d = 1'b0;
    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
      if (valid_q[i] && !timeout_q[i] && (dist_q[i] < bus.threshold)) begin
        stop_d = 1'b1;
      end
    end
  end

  always_comb begin
    trig = '0;
    if (state_q == TRIG) begin
      for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          trig[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    dist_mux = '1;
    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
      if (bus.dist_sel == IDX_W'(i)) begin
        dist_mux = dist_q[i];
      end
    end
  end

  assign bus.trigger     = trig;
  assign bus.dist_out    = dist_mux;
  assign bus.dist_valid  = valid_q;
  assign bus.timeout     = timeout_q;
  assign bus.active_idx  = idx_q;
  assign bus.sample_done = sample_done_q;
  assign bus.stop        = stop_q;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// tb_ultrasonic_scheduler
//   Testbench for ultrasonic_scheduler. It checks the following:
//     - a directed vector table;
//     - hand-written mid-sample enable drop and reset sequences;
//     - randomised echo widths against a sample-level reference model.
//   The bench follows the ULTRASONIC_AVG_EN build option of the design.
module tb_ultrasonic_scheduler;
  localparam int NS   = 3;
  localparam int CW   = 25;
  localparam int TRIG = 10;
  localparam int ETO  = 200;
  localparam int GRD  = 20;
  localparam longint ONES = (longint'(1) << CW) - 1;
`ifdef ULTRASONIC_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ultrasonic_scheduler_if #(.NUM_SENSORS(NS), .CNT_W(CW)) bus ();

  ultrasonic_scheduler #(
    .NUM_SENSORS (NS),
    .CNT_W       (CW),
    .TRIG_CYCLES (TRIG),
    .ECHO_TIMEOUT(ETO),
    .GUARD_CYCLES(GRD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_fall = -1;
  int pstart [NS] = '{default: 0};
  int pend   [NS] = '{default: 0};

  always @(posedge clk) cyc <= cyc + 1;

  // Echo pins follow per-sensor pulse windows given in absolute cycles.
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) bus.echo[i] = (cyc >= pstart[i]) && (cyc < pend[i]);
  end

  // Sample-level reference model
  logic [CW-1:0] m_d  [NS];
  bit            m_v  [NS];
  bit            m_to [NS];

  function automatic void m_reset();
    for (int i = 0; i < NS; i++) begin
      m_d[i] = '1; m_v[i] = 1'b0; m_to[i] = 1'b0;
    end
  endfunction

  function automatic bit m_stop(input logic [CW-1:0] thr);
    for (int i = 0; i < NS; i++)
      if (m_v[i] && !m_to[i] && m_d[i] < thr) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_sample(input int idx, input bit to, input int w);
    if (to) begin
      m_d[idx] = '1;
    end else if (AVG && m_v[idx] && !m_to[idx]) begin
      m_d[idx] = CW'((longint'(m_d[idx]) + w) >> 1);
    end else begin
      m_d[idx] = CW'(w);
    end
    m_to[idx] = to;
    m_v[idx]  = 1'b1;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Runs one sensor slot:
  //   1. wait for the trigger and check its shape;
  //   2. schedule the echo pulse;
  //   3. capture the outputs at the sample_done cycle and on the cycle after.
  task automatic run_sensor(input int idx, input int delay, input int w, input bit drive,
                            input int drop_at, output longint d, output bit to,
                            output bit st_before, output bit st_after);
    int n, hi, t;
    bit ovl, got;
    d = -1; to = 1'b0; st_before = 1'b0; st_after = 1'b0;
    bus.dist_sel = 2'(idx);
    n = 0;
    while (bus.trigger == '0 && n < 2000) begin @(negedge clk); n++; end
    if (bus.trigger == '0) begin expire("trig_start"); return; end
    chk("trig_sel", bus.trigger, 1 << idx);
    chk("active_idx", bus.active_idx, idx);
    if (last_fall >= 0) chk("trig_gap_ge_guard", (cyc - last_fall) >= GRD, 1);
    hi = 0; ovl = 1'b0;
    while (bus.trigger != '0 && hi < 100) begin
      if (bus.trigger != NS'(1 << idx)) ovl = 1'b1;
      hi++;
      @(negedge clk);
    end
    chk("trig_width", hi, TRIG);
    chk("trig_onehot", ovl, 0);
    last_fall = cyc;
    if (drive) begin
      pstart[idx] = cyc + delay + 1;
      pend[idx]   = cyc + delay + 1 + w;
    end
    t = 0; got = 1'b0;
    while (!got && t < 600) begin
      if (t == drop_at) bus.enable = 1'b0;
      @(negedge clk);
      t++;
      if (bus.sample_done) got = 1'b1;
    end
    if (!got) begin expire("sample_done"); return; end
    d = bus.dist_out;
    to = bus.timeout[idx];
    st_before = bus.stop;
    chk("dist_valid", bus.dist_valid[idx], 1);
    @(negedge clk);
    chk("sdone_pulse", bus.sample_done, 0);
    st_after = bus.stop;
  endtask

  task automatic model_run(input int idx, input int delay, input int w, input bit drive,
                           input int drop_at, input int thr);
    longint d;
    bit to, sb, sa, exp_to, exp_sb;
    bus.threshold = CW'(thr);
    exp_to = !drive || (w > ETO);
    exp_sb = m_stop(CW'(thr));
    run_sensor(idx, delay, w, drive, drop_at, d, to, sb, sa);
    m_sample(idx, exp_to, w);
    chk("m_dist", d, longint'(m_d[idx]));
    chk("m_timeout", to, exp_to);
    chk("m_stop_pre", sb, exp_sb);
    chk("m_stop_post", sa, m_stop(CW'(thr)));
  endtask

  typedef struct {
    int     idx;
    int     delay;
    int     w;
    bit     drive;
    longint d_raw;
    longint d_avg;
    bit     to;
    bit     st_raw;
    bit     st_avg;
  } vec_t;

  vec_t   tbl [10];
  longint d;
  bit     to, sb, sa, prev_st, quiet_bad;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // threshold = 45 throughout the table
    tbl[0] = '{0, 3,  40, 1'b1,   40,   40, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1, 0,   0, 1'b0, ONES, ONES, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{2, 7,  60, 1'b1,   60,   60, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{0, 2,  61, 1'b1,   61,   50, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1, 0, 250, 1'b1, ONES, ONES, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{2, 4,  30, 1'b1,   30,   45, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{0, 1,  30, 1'b1,   30,   40, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1, 6,  45, 1'b1,   45,   45, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{2, 0,  90, 1'b1,   90,   67, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{0, 9, 100, 1'b1,  100,   70, 1'b0, 1'b0, 1'b0};

    m_reset();
    bus.enable = 1'b0;
    bus.threshold = CW'(45);
    bus.dist_sel = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_trigger", bus.trigger, 0);
    chk("rst_valid", bus.dist_valid, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_sdone", bus.sample_done, 0);
    chk("rst_stop", bus.stop, 0);
    chk("rst_idx", bus.active_idx, 0);
    chk("rst_dist", bus.dist_out, ONES);
    rst = 1'b0;
    quiet_bad = 1'b0;
    repeat (5) begin @(negedge clk); if (bus.trigger != '0) quiet_bad = 1'b1; end
    chk("disabled_quiet", quiet_bad, 0);

    // Directed table
    bus.enable = 1'b1;
    prev_st = 1'b0;
    for (int k = 0; k < 10; k++) begin
      run_sensor(tbl[k].idx, tbl[k].delay, tbl[k].w, tbl[k].drive, -1, d, to, sb, sa);
      chk($sformatf("tbl%0d_dist", k), d, AVG ? tbl[k].d_avg : tbl[k].d_raw);
      chk($sformatf("tbl%0d_timeout", k), to, tbl[k].to);
      chk($sformatf("tbl%0d_stop_pre", k), sb, prev_st);
      chk($sformatf("tbl%0d_stop_post", k), sa, AVG ? tbl[k].st_avg : tbl[k].st_raw);
      prev_st = AVG ? tbl[k].st_avg : tbl[k].st_raw;
      m_sample(tbl[k].idx, tbl[k].to, tbl[k].w);
    end

    // Drop enable while sensor 2 is measuring
    model_run(1, 2, 35, 1'b1, -1, 45);
    model_run(2, 0, 80, 1'b1, 40, 45);
    quiet_bad = 1'b0;
    repeat (150) begin @(negedge clk); if (bus.trigger != '0) quiet_bad = 1'b1; end
    chk("drop_idle_quiet", quiet_bad, 0);
    chk("drop_idx_wrap", bus.active_idx, 0);
    bus.enable = 1'b1;
    model_run(0, 5, 70, 1'b1, -1, 45);

    // Reset while triggering
    begin
      int n = 0;
      while (bus.trigger == '0 && n < 2000) begin @(negedge clk); n++; end
      if (bus.trigger == '0) expire("rst_trig_start");
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_trigger", bus.trigger, 0);
    chk("midrst_valid", bus.dist_valid, 0);
    chk("midrst_timeout", bus.timeout, 0);
    chk("midrst_stop", bus.stop, 0);
    chk("midrst_idx", bus.active_idx, 0);
    for (int i = 0; i < NS; i++) begin pstart[i] = 0; pend[i] = 0; end
    m_reset();
    last_fall = -1;
    @(negedge clk);
    rst = 1'b0;

    // Randomised slots
    for (int k = 0; k < 24; k++) begin
      int r, w, dl, thr;
      bit drv;
      r   = $urandom_range(0, 99);
      dl  = $urandom_range(0, 40);
      thr = $urandom_range(10, 200);
      drv = 1'b1;
      if (r < 12) begin
        drv = 1'b0; w = 0;
      end else if (r < 22) begin
        w = $urandom_range(215, 260);
      end else begin
        w = $urandom_range(1, 190);
      end
      model_run(k % NS, dl, w, drv, -1, thr);
    end

    // Readback of every sensor through dist_sel
    for (int i = 0; i < NS; i++) begin
      bus.dist_sel = 2'(i);
      #1;
      chk($sformatf("rb%0d_dist", i), bus.dist_out, longint'(m_d[i]));
      chk($sformatf("rb%0d_valid", i), bus.dist_valid[i], m_v[i]);
      chk($sformatf("rb%0d_timeout", i), bus.timeout[i], m_to[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
